axi4_lite_rom_rd_arbiter: RTL and testbench
===========================================

Name: axi4_lite_rom_rd_arbiter

Overview:
- Shares one AXI4-Lite read-only slave (the on-chip ROM) among NUM_REQ read masters, e.g. instruction fetch, data load and debug.
- Round-robin arbitration, one outstanding transaction at a time.
- Sits between the requesters and the ROM read channel.
- Requester side is flat per-requester AR/R signals; ROM side is a single AR/R master port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, read data width.
- ADDR_WIDTH, 10, read address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- s_ar_valid  in  NUM_REQ  per-requester address valid.
- s_ar_ready  out  NUM_REQ  per-requester address accepted.
- s_ar_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_r_valid  out  NUM_REQ  per-requester read data valid.
- s_r_ready  in  NUM_REQ  per-requester read data ready.
- s_r_data  out  DATA_WIDTH  read data, broadcast to all requesters; qualified by s_r_valid[i].
- m_ar_valid  out  1  address valid to ROM.
- m_ar_ready  in  1  ROM address ready.
- m_ar_addr  out  ADDR_WIDTH  address to ROM.
- m_r_valid  in  1  ROM data valid.
- m_r_ready  out  1  data ready to ROM.
- m_r_data  in  DATA_WIDTH  ROM data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - Outputs: s_ar_ready=0, s_r_valid=0, m_ar_valid=0, m_r_ready=0, busy=0, m_ar_addr=0, s_r_data=0.
  - Internal: state=IDLE, rr_ptr=0, grant_q=0, addr_q=0.
- State IDLE:
  - Winner = first set bit of s_ar_valid, searching upward from rr_ptr with wrap.
  - If any s_ar_valid: assert s_ar_ready[winner]=1 combinationally, same cycle; all other ready bits stay 0.
  - On that edge register grant_q=winner and addr_q=s_ar_addr[winner]; go to ADDR.
  - No valid: stay in IDLE.
- State ADDR:
  - m_ar_valid=1, m_ar_addr=addr_q, held stable until m_ar_ready.
  - On m_ar_valid & m_ar_ready, go to DATA.
  - All s_ar_ready=0.
- State DATA:
  - s_r_valid[grant_q]=m_r_valid; all other s_r_valid bits 0.
  - m_r_ready=s_r_ready[grant_q]; s_r_data=m_r_data.
  - On m_r_valid & m_r_ready: go to IDLE and set rr_ptr=(grant_q+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Latency:
  - Address handshake in cycle N; m_ar_valid asserted in cycle N+1.
  - With the ROM accepting immediately and returning data the next cycle, data reaches the requester in N+2.
  - Minimum spacing between grants is 3 cycles.
- Outputs toward the ROM are never driven in IDLE, so the AR path has no combinational feedthrough.
- Requests arriving during ADDR/DATA are held pending (AXI valid-hold rule) and arbitrated in the next IDLE.
- A requester that drops s_ar_valid before its grant simply loses its turn; this is a protocol violation by that requester, not checked.
- Reset mid-transaction: everything returns to IDLE immediately; ROM-side handshakes in flight are abandoned. The ROM shares rst_n, so both sides resync.
- Simultaneous valids: exactly one grant per IDLE cycle.
- An unselected s_r_ready has no effect.
- Out-of-range / default state: go to IDLE; `ifndef SYNTHESIS emits $error.

Optional Feature:
- ROM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr is removed and the search always starts at 0.
- Not defined: round-robin as specified above.

Decomposition:
- Package axi4_lite_arb_pkg holds:
  - enum arb_state_t {IDLE, ADDR, DATA}, 2 bits.
  - function clog2_min1(n), giving GRANT_W = max(1, $clog2(NUM_REQ)).
- Sub-module rr_arbiter(NUM_REQ):
  - Combinational: req, ptr -> one-hot gnt and gnt_idx.
  - Contains the ROM_ARB_FIXED_PRIO_EN switch.
  - Reusable for a future write-channel arbiter.

Test Plan:
- Single request: s_ar_valid=4'b0010, addr 0x005, ROM word 5=0xDEADBEEF -> s_ar_ready=4'b0010 for one cycle; m_ar_addr=0x005 next cycle; s_r_valid[1] with s_r_data=0xDEADBEEF; busy low afterwards.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; with ROM_ARB_FIXED_PRIO_EN, requester 0 wins every grant.
- s_r_ready[2] held low 5 cycles while granted -> s_r_valid[2] stays high, m_r_ready=0, s_r_data stable; no other grant until it accepts.
- Requester 3 asserts during DATA of requester 0 -> s_ar_ready[3] not before the next IDLE; granted then, and rr_ptr=1 skips to 3.
- rst_n pulsed low during ADDR -> next cycle all outputs at reset values, state IDLE, rr_ptr=0; a subsequent request completes normally.
- ROM stalls m_ar_ready for 3 cycles -> m_ar_valid/m_ar_addr held constant; s_ar_addr changes are ignored.

Source files
------------

// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite ROM read arbiter.
// Holds the FSM state encoding and the grant-index width helper.
package axi4_lite_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   // Grant index width; never zero, even for a single requester.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request picker: round-robin from ptr, or fixed lowest-index-first
// when ROM_ARB_FIXED_PRIO_EN is defined (ptr port then disappears). Zero latency, no backpressure.
module rr_arbiter
   import axi4_lite_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int GRANT_W = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
`ifndef ROM_ARB_FIXED_PRIO_EN
   input  logic [GRANT_W-1:0] ptr,
`endif
   output logic [NUM_REQ-1:0] gnt,
   output logic [GRANT_W-1:0] gnt_idx
);

   always_comb begin
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i >= int'(ptr))) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = GRANT_W'(i);
         end
      end
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = GRANT_W'(i);
         end
      end
   end

endmodule

// File: rtl/axi4_lite_rom_rd_arbiter.sv
// Shares one AXI4-Lite ROM read port among NUM_REQ masters, one transaction at a time; AR to ROM
// one cycle after grant, grants >= 3 cycles apart; R stalls on the winner's s_r_ready. ROM_ARB_FIXED_PRIO_EN selects fixed priority.
module axi4_lite_rom_rd_arbiter
   import axi4_lite_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            s_ar_valid,
   output logic [NUM_REQ-1:0]            s_ar_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_ar_addr,
   output logic [NUM_REQ-1:0]            s_r_valid,
   input  logic [NUM_REQ-1:0]            s_r_ready,
   output logic [DATA_WIDTH-1:0]         s_r_data,
   output logic                          m_ar_valid,
   input  logic                          m_ar_ready,
   output logic [ADDR_WIDTH-1:0]         m_ar_addr,
   input  logic                          m_r_valid,
   output logic                          m_r_ready,
   input  logic [DATA_WIDTH-1:0]         m_r_data,
   output logic                          busy
);

   localparam int GRANT_W = clog2_min1(NUM_REQ);

   arb_state_t              state_q, state_d;
   logic [GRANT_W-1:0]      grant_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [NUM_REQ-1:0]      arb_gnt;
   logic [GRANT_W-1:0]      arb_idx;
   logic [ADDR_WIDTH-1:0]   sel_addr;
`ifndef ROM_ARB_FIXED_PRIO_EN
   logic [GRANT_W-1:0]      rr_ptr;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req     (s_ar_valid),
`ifndef ROM_ARB_FIXED_PRIO_EN
      .ptr     (rr_ptr),
`endif
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // One-hot mux keeps the address pick free of variable part-selects.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) sel_addr = s_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (|s_ar_valid) state_d = ADDR;
         ADDR: if (m_ar_ready) state_d = DATA;
         DATA: if (m_r_valid && s_r_ready[grant_q]) state_d = IDLE;
         default: begin
            state_d = IDLE;
`ifndef SYNTHESIS
            $error("axi4_lite_rom_rd_arbiter: illegal state %0d", state_q);
`endif
         end
      endcase
   end

   always_comb begin
      s_ar_ready = '0;
      s_r_valid  = '0;
      s_r_data   = '0;
      m_ar_valid = 1'b0;
      m_ar_addr  = '0;
      m_r_ready  = 1'b0;
      busy       = (state_q != IDLE);
      case (state_q)
         IDLE: s_ar_ready = arb_gnt;
         ADDR: begin
            m_ar_valid = 1'b1;
            m_ar_addr  = addr_q;
         end
         DATA: begin
            s_r_valid[grant_q] = m_r_valid;
            m_r_ready          = s_r_ready[grant_q];
            s_r_data           = m_r_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= '0;
         addr_q  <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
         rr_ptr  <= '0;
`endif
      end else begin
         if (state_q == IDLE && |s_ar_valid) begin
            grant_q <= arb_idx;
            addr_q  <= sel_addr;
         end
`ifndef ROM_ARB_FIXED_PRIO_EN
         // Pointer moves only on completion, so an abandoned grant never advances it.
         if (state_q == DATA && m_r_valid && m_r_ready) begin
            rr_ptr <= (grant_q == GRANT_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_axi4_lite_rom_rd_arbiter.sv
// Randomized bench for axi4_lite_rom_rd_arbiter: requester and ROM agents plus a
// transaction-level reference model; directed scenarios followed by a random soak.
module tb_axi4_lite_rom_rd_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    s_ar_valid = '0;
   logic [N-1:0]    s_ar_ready;
   logic [N*AW-1:0] s_ar_addr = '0;
   logic [N-1:0]    s_r_valid;
   logic [N-1:0]    s_r_ready = '0;
   logic [DW-1:0]   s_r_data;
   logic            m_ar_valid;
   logic            m_ar_ready = 1'b0;
   logic [AW-1:0]   m_ar_addr;
   logic            m_r_valid = 1'b0;
   logic            m_r_ready;
   logic [DW-1:0]   m_r_data = '0;
   logic            busy;

   axi4_lite_rom_rd_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_ar_valid (s_ar_valid),
      .s_ar_ready (s_ar_ready),
      .s_ar_addr  (s_ar_addr),
      .s_r_valid  (s_r_valid),
      .s_r_ready  (s_r_ready),
      .s_r_data   (s_r_data),
      .m_ar_valid (m_ar_valid),
      .m_ar_ready (m_ar_ready),
      .m_ar_addr  (m_ar_addr),
      .m_r_valid  (m_r_valid),
      .m_r_ready  (m_r_ready),
      .m_r_data   (m_r_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Requester agents
   logic [N-1:0]  a_vld = '0;
   logic [N-1:0]  a_wait = '0;
   logic [N-1:0]  en_mask = '0;
   logic [AW-1:0] a_addr [N];
   logic [DW-1:0] a_exp  [N];
   int            budget [N];
   int            req_prob = 100, ar_prob = 100, rrdy_prob = 100, rdelay_max = 0;
   bit            fixed_addr_en = 1'b0;
   logic [AW-1:0] fixed_addr = '0;

   // ROM agent
   bit            rom_busy = 1'b0;
   logic [AW-1:0] rom_addr = '0;
   int            rom_dly = 0;

   // Reference model: which requester owns the single outstanding read
   bit            m_busy = 1'b0;
   bit            m_issued = 1'b0;
   int            m_owner = 0;
   int            m_ptr = 0;
   logic [AW-1:0] m_addr = '0;

   int            grant_log[$];
   int            cyc = 0;
   int            t_gnt = 0, t_ar = 0, t_r = 0;
   logic [DW-1:0] last_rdata = '0;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      if (a == 10'h005) return 32'hDEAD_BEEF;
      return {6'h2A, a, ~a, 6'h15};
   endfunction

   // Round-robin: nearest valid requester at or after ptr, with wrap.
   function automatic int pick(input logic [N-1:0] v, input int ptr);
      int best = -1;
      int bestd = N;
`ifdef ROM_ARB_FIXED_PRIO_EN
      ptr = 0;
`endif
      for (int i = 0; i < N; i++) begin
         if (v[i] && ((i - ptr + N) % N) < bestd) begin
            bestd = (i - ptr + N) % N;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (!a_vld[i] && !a_wait[i] && en_mask[i] && budget[i] > 0 &&
             int'($urandom_range(99)) < req_prob) begin
            a_vld[i]  = 1'b1;
            a_addr[i] = fixed_addr_en ? fixed_addr : AW'($urandom);
            budget[i] = budget[i] - 1;
         end
         s_ar_valid[i]          = a_vld[i];
         s_ar_addr[i*AW +: AW]  = a_vld[i] ? a_addr[i] : AW'($urandom);
         s_r_ready[i]           = (int'($urandom_range(99)) < rrdy_prob);
      end
      m_ar_ready = !rom_busy && (int'($urandom_range(99)) < ar_prob);
      m_r_valid  = rom_busy && (rom_dly == 0);
      m_r_data   = m_r_valid ? rom_word(rom_addr) : DW'($urandom);
   endtask

   task automatic step();
      int           win;
      bit           in_data;
      logic [N-1:0] exp_ardy;
      @(negedge clk);
      drive();
      #1;
      cyc++;
      win      = pick(s_ar_valid, m_ptr);
      in_data  = m_busy && m_issued;
      exp_ardy = (!m_busy && win >= 0) ? (N'(1) << win) : '0;
      chk("s_ar_ready", s_ar_ready, exp_ardy);
      chk("busy", busy, m_busy);
      chk("m_ar_valid", m_ar_valid, m_busy && !m_issued);
      chk("m_ar_addr", m_ar_addr, (m_busy && !m_issued) ? m_addr : '0);
      chk("s_r_valid", s_r_valid, (in_data && m_r_valid) ? (N'(1) << m_owner) : '0);
      chk("m_r_ready", m_r_ready, in_data ? s_r_ready[m_owner] : 1'b0);
      chk("s_r_data", s_r_data, in_data ? m_r_data : '0);

      if (!m_busy && win >= 0) begin
         m_busy   = 1'b1;
         m_issued = 1'b0;
         m_owner  = win;
         m_addr   = s_ar_addr[win*AW +: AW];
      end else if (m_busy && !m_issued && m_ar_ready) begin
         m_issued = 1'b1;
      end else if (in_data && m_r_valid && s_r_ready[m_owner]) begin
         m_busy = 1'b0;
         m_ptr  = (m_owner + 1) % N;
      end

      for (int i = 0; i < N; i++) begin
         if (a_vld[i] && s_ar_ready[i]) begin
            a_vld[i]  = 1'b0;
            a_wait[i] = 1'b1;
            a_exp[i]  = rom_word(a_addr[i]);
            grant_log.push_back(i);
            t_gnt = cyc;
         end
         if (a_wait[i] && s_r_valid[i] && s_r_ready[i]) begin
            chk("rdata_e2e", s_r_data, a_exp[i]);
            a_wait[i]  = 1'b0;
            last_rdata = s_r_data;
            t_r        = cyc;
         end
      end
      if (m_ar_valid && m_ar_ready) t_ar = cyc;

      if (!rom_busy && m_ar_valid && m_ar_ready) begin
         rom_busy = 1'b1;
         rom_addr = m_ar_addr;
         rom_dly  = int'($urandom_range(rdelay_max));
      end else if (rom_busy && m_r_valid && m_r_ready) begin
         rom_busy = 1'b0;
      end else if (rom_busy && rom_dly > 0) begin
         rom_dly--;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n      = 1'b0;
      s_ar_valid = '0;
      s_ar_addr  = '0;
      s_r_ready  = '0;
      m_ar_ready = 1'b0;
      m_r_valid  = 1'b0;
      m_r_data   = '0;
      #1;
      chk("rst s_ar_ready", s_ar_ready, '0);
      chk("rst s_r_valid", s_r_valid, '0);
      chk("rst m_ar_valid", m_ar_valid, 1'b0);
      chk("rst m_r_ready", m_r_ready, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst m_ar_addr", m_ar_addr, '0);
      chk("rst s_r_data", s_r_data, '0);
      a_vld    = '0;
      a_wait   = '0;
      en_mask  = '0;
      rom_busy = 1'b0;
      m_busy   = 1'b0;
      m_issued = 1'b0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) budget[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic bit work_left();
      for (int i = 0; i < N; i++) begin
         if (a_vld[i] || a_wait[i] || (en_mask[i] && budget[i] > 0)) return 1'b1;
      end
      return m_busy;
   endfunction

   task automatic wait_idle(input string tag, input int max);
      int k = 0;
      while (k < max && work_left()) begin
         step();
         k++;
      end
      chk(tag, {a_vld, a_wait, m_busy}, '0);
   endtask

   initial begin
      int exp_order [5];
      int idx;
      int cnt;
      for (int i = 0; i < N; i++) begin
         budget[i] = 0;
         a_addr[i] = '0;
         a_exp[i]  = '0;
      end
      reset_dut();

      // Single request, ROM immediate: latency and data routing
      en_mask = 4'b0010; budget[1] = 1; fixed_addr_en = 1'b1; fixed_addr = 10'h005;
      wait_idle("single drain", 40);
      chk("single grant count", grant_log.size(), 1);
      chk("single grant id", grant_log[0], 1);
      chk("single ar latency", t_ar - t_gnt, 1);
      chk("single r latency", t_r - t_gnt, 2);
      chk("single rdata", last_rdata, 32'hDEAD_BEEF);
      fixed_addr_en = 1'b0;

      // All four requesting continuously from reset
      reset_dut();
`ifdef ROM_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      idx = grant_log.size();
      en_mask = 4'b1111;
      for (int i = 0; i < N; i++) budget[i] = 5;
      wait_idle("all4 drain", 400);
      for (int k = 0; k < 5; k++) chk($sformatf("all4 order[%0d]", k), grant_log[idx+k], exp_order[k]);

      // Requester 2 stalls R; no other grant meanwhile
      en_mask = 4'b0100; budget[2] = 1; rrdy_prob = 0;
      for (int k = 0; k < 50 && !s_r_valid[2]; k++) step();
      chk("hold rvld2 reached", s_r_valid[2], 1'b1);
      en_mask = 4'b0101; budget[0] = 1;
      idx = grant_log.size();
      cnt = 0;
      repeat (5) begin
         step();
         if (s_r_valid[2]) cnt++;
      end
      chk("hold rvld2 cycles", cnt, 5);
      chk("hold no new grant", grant_log.size(), idx);
      rrdy_prob = 100;
      wait_idle("hold drain", 60);
      chk("hold next grant", grant_log[grant_log.size()-1], 0);

      // Requester 3 arrives during requester 0's DATA phase
      en_mask = 4'b0001; budget[0] = 1; rrdy_prob = 0;
      for (int k = 0; k < 50 && !(m_busy && m_issued); k++) step();
      chk("late req in data", m_busy && m_issued, 1'b1);
      en_mask = 4'b1001; budget[3] = 1;
      repeat (3) step();
      chk("late req held", s_ar_ready[3], 1'b0);
      rrdy_prob = 100;
      wait_idle("late drain", 60);
      chk("late order a", grant_log[grant_log.size()-2], 0);
      chk("late order b", grant_log[grant_log.size()-1], 3);

      // Reset while in ADDR; pointer must restart at 0
      en_mask = 4'b0010; budget[1] = 1;
      wait_idle("pre-rst drain", 40);
      en_mask = 4'b0100; budget[2] = 1; ar_prob = 0;
      for (int k = 0; k < 50 && !m_ar_valid; k++) step();
      chk("rst in addr reached", m_ar_valid, 1'b1);
      reset_dut();
      ar_prob = 100;
      idx = grant_log.size();
      en_mask = 4'b1111;
      for (int i = 0; i < N; i++) budget[i] = 1;
      wait_idle("post-rst drain", 80);
      chk("post-rst first grant", grant_log[idx], 0);

      // ROM holds off m_ar_ready for 3 cycles
      en_mask = 4'b0010; budget[1] = 1; fixed_addr_en = 1'b1; fixed_addr = 10'h3A5; ar_prob = 0;
      for (int k = 0; k < 50 && !m_ar_valid; k++) step();
      repeat (3) step();
      chk("stall m_ar_valid", m_ar_valid, 1'b1);
      chk("stall m_ar_addr", m_ar_addr, 10'h3A5);
      ar_prob = 100;
      wait_idle("stall drain", 40);
      fixed_addr_en = 1'b0;

      // Random soak
      en_mask = 4'b1111;
      for (int i = 0; i < N; i++) budget[i] = 300;
      req_prob = 35; ar_prob = 60; rdelay_max = 3; rrdy_prob = 60;
      repeat (3000) step();
      for (int i = 0; i < N; i++) budget[i] = 0;
      wait_idle("random drain", 400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
